// File: rtl/oven_bake_controller_if.sv
// Oven controller bundle: operator inputs, temperature sense and
// the registered outputs that go to the heater and the display.
interface oven_bake_controller_if;
  logic        power;
  logic        btn_up;
  logic        btn_down;
  logic        btn_mode;
  logic        btn_start;
  logic        tick;
  logic [10:0] cur_temp;
  logic        heater_on;
  logic [10:0] target_temp;
  logic [16:0] time_left;
  logic [2:0]  state;
  logic        done_beep;

  modport master (
    output power, btn_up, btn_down,
    output btn_mode, btn_start, tick,
    output cur_temp,
    input  heater_on, target_temp,
    input  time_left, state, done_beep
  );

  modport slave (
    input  power, btn_up, btn_down,
    input  btn_mode, btn_start, tick,
    input  cur_temp,
    output heater_on, target_temp,
    output time_left, state, done_beep
  );
endinterface

// File: rtl/oven_bake_controller.sv
// Oven sequencer: temperature/time entry, preheat, bake with
// hysteresis heater control, and a timed done beep.
module oven_bake_controller #(
  parameter int TEMP_DEFAULT = 350,
  parameter int TEMP_MIN     = 170,
  parameter int TEMP_MAX     = 550,
  parameter int TEMP_STEP    = 5,
  parameter int TIME_STEP    = 30,
  parameter int TIME_MAX     = 5999,
  parameter int HYST         = 5,
  parameter int DONE_SECS    = 10
) (
  input logic                  clk,
  input logic                  rst,
  oven_bake_controller_if.slave bus
);

  localparam int CW = $clog2(DONE_SECS + 1);

  localparam logic [10:0] T_DEF  = 11'(TEMP_DEFAULT);
  localparam logic [10:0] T_MIN  = 11'(TEMP_MIN);
  localparam logic [10:0] T_MAX  = 11'(TEMP_MAX);
  localparam logic [10:0] T_STEP = 11'(TEMP_STEP);
  localparam logic [10:0] T_HYST = 11'(HYST);
  localparam logic [16:0] S_STEP = 17'(TIME_STEP);
  localparam logic [16:0] S_MAX  = 17'(TIME_MAX);
  localparam logic [CW-1:0] C_END = CW'(DONE_SECS - 1);

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    SET_TEMP = 3'd1,
    SET_TIME = 3'd2,
    PREHEAT  = 3'd3,
    BAKE     = 3'd4,
    DONE     = 3'd5
  } st_t;

  logic [2:0]    st_q, st_n;
  logic          heat_q, heat_n;
  logic [10:0]   tgt_q, tgt_n;
  logic [16:0]   tl_q, tl_n;
  logic          beep_q, beep_n;
  logic [CW-1:0] cnt_q, cnt_n;

  logic up, dn, any_btn;

  assign up = bus.btn_up & ~bus.btn_down;
  assign dn = bus.btn_down & ~bus.btn_up;
  assign any_btn = bus.btn_up | bus.btn_down
                 | bus.btn_mode | bus.btn_start;

  always_comb begin
    st_n   = st_q;
    heat_n = heat_q;
    tgt_n  = tgt_q;
    tl_n   = tl_q;
    cnt_n  = cnt_q;
    if (!bus.power) begin
      st_n   = OFF;
      heat_n = 1'b0;
      tl_n   = '0;
    end else begin
      case (st_q)
        OFF: begin
          st_n   = SET_TEMP;
          heat_n = 1'b0;
        end
        SET_TEMP, SET_TIME: begin
          heat_n = 1'b0;
          unique case (1'b1)
            bus.btn_start: begin
              if (tl_q != '0) st_n = PREHEAT;
            end
            bus.btn_mode: begin
              st_n = (st_q == SET_TEMP) ? SET_TIME
                                        : SET_TEMP;
            end
            up: begin
              if (st_q == SET_TEMP)
                tgt_n = (tgt_q + T_STEP > T_MAX)
                      ? T_MAX : tgt_q + T_STEP;
              else
                tl_n = (tl_q + S_STEP > S_MAX)
                     ? S_MAX : tl_q + S_STEP;
            end
            dn: begin
              if (st_q == SET_TEMP)
                tgt_n = (tgt_q < T_MIN + T_STEP)
                      ? T_MIN : tgt_q - T_STEP;
              else
                tl_n = (tl_q < S_STEP)
                     ? '0 : tl_q - S_STEP;
            end
            default: ;
          endcase
        end
        PREHEAT: begin
          if (bus.btn_start) begin
            st_n   = SET_TEMP;
            heat_n = 1'b0;
          end else if (bus.cur_temp >= tgt_q) begin
            st_n   = BAKE;
            heat_n = 1'b0;
          end else begin
            heat_n = 1'b1;
          end
        end
        BAKE: begin
          if (bus.btn_start) begin
            st_n   = SET_TEMP;
            heat_n = 1'b0;
          end else begin
            if (bus.cur_temp >= tgt_q)
              heat_n = 1'b0;
            else if (bus.cur_temp < tgt_q - T_HYST)
              heat_n = 1'b1;
            if (bus.tick && tl_q != '0) begin
              tl_n = tl_q - 17'd1;
              if (tl_q == 17'd1) begin
                st_n   = DONE;
                heat_n = 1'b0;
                cnt_n  = '0;
              end
            end
          end
        end
        DONE: begin
          heat_n = 1'b0;
          if (any_btn) begin
            st_n = SET_TEMP;
          end else if (bus.tick) begin
            if (cnt_q == C_END) begin
              st_n  = SET_TEMP;
              cnt_n = '0;
            end else begin
              cnt_n = cnt_q + CW'(1);
            end
          end
        end
        default: begin
          st_n   = OFF;
          heat_n = 1'b0;
        end
      endcase
    end
    beep_n = (st_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= OFF;
      heat_q <= 1'b0;
      tgt_q  <= T_DEF;
      tl_q   <= '0;
      beep_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_n;
      heat_q <= heat_n;
      tgt_q  <= tgt_n;
      tl_q   <= tl_n;
      beep_q <= beep_n;
      cnt_q  <= cnt_n;
    end
  end

  assign bus.state       = st_q;
  assign bus.heater_on   = heat_q;
  assign bus.target_temp = tgt_q;
  assign bus.time_left   = tl_q;
  assign bus.done_beep   = beep_q;

endmodule

// File: tb/tb_oven_bake_controller.sv
// Directed bench for the oven sequencer with hand-computed
// expectations checked by immediate assertions.
module tb_oven_bake_controller;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;

  oven_bake_controller_if bus ();

  oven_bake_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic up(input int n);
    for (int i = 0; i < n; i++) begin
      bus.btn_up = 1'b1; step(); bus.btn_up = 1'b0;
    end
  endtask

  task automatic down(input int n);
    for (int i = 0; i < n; i++) begin
      bus.btn_down = 1'b1; step(); bus.btn_down = 1'b0;
    end
  endtask

  task automatic mode();
    bus.btn_mode = 1'b1; step(); bus.btn_mode = 1'b0;
  endtask

  task automatic start();
    bus.btn_start = 1'b1; step(); bus.btn_start = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1; step(); bus.tick = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.power = 1'b1;
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_start = 1'b0;
    bus.tick = 1'b0;
    bus.cur_temp = 11'd0;
    step(); step();
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_tgt", 32'(bus.target_temp), 350);
    chk("rst_tl", 32'(bus.time_left), 0);
    chk("rst_heat", 32'(bus.heater_on), 0);
    chk("rst_beep", 32'(bus.done_beep), 0);
    rst = 1'b0;
    step();
    chk("to_set_temp", 32'(bus.state), 1);

    up(45);
    chk("tgt_max", 32'(bus.target_temp), 550);
    down(80);
    chk("tgt_min", 32'(bus.target_temp), 170);
    up(36);
    chk("tgt_350", 32'(bus.target_temp), 350);
    bus.btn_up = 1'b1; bus.btn_down = 1'b1;
    step();
    bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    chk("up_dn_both", 32'(bus.target_temp), 350);

    mode();
    chk("to_set_time", 32'(bus.state), 2);
    up(3);
    chk("tl_90", 32'(bus.time_left), 90);
    down(4);
    chk("tl_0", 32'(bus.time_left), 0);
    down(1);
    chk("tl_no_uflow", 32'(bus.time_left), 0);
    start();
    chk("start_tl0", 32'(bus.state), 2);

    up(2);
    chk("tl_60", 32'(bus.time_left), 60);
    bus.cur_temp = 11'd300;
    start();
    chk("preheat", 32'(bus.state), 3);
    step();
    chk("pre_heat_on", 32'(bus.heater_on), 1);
    bus.cur_temp = 11'd350;
    step();
    chk("bake", 32'(bus.state), 4);
    chk("bake_heat0", 32'(bus.heater_on), 0);
    bus.cur_temp = 11'd344;
    step();
    chk("hyst_on", 32'(bus.heater_on), 1);
    bus.cur_temp = 11'd347;
    step();
    chk("hyst_hold", 32'(bus.heater_on), 1);
    bus.cur_temp = 11'd350;
    step();
    chk("hyst_off", 32'(bus.heater_on), 0);

    ticks(20);
    chk("tl_40", 32'(bus.time_left), 40);
    start();
    chk("pause_state", 32'(bus.state), 1);
    chk("pause_tl", 32'(bus.time_left), 40);
    chk("pause_heat", 32'(bus.heater_on), 0);

    start();
    chk("resume_pre", 32'(bus.state), 3);
    step();
    chk("resume_bake", 32'(bus.state), 4);
    ticks(38);
    chk("tl_2", 32'(bus.time_left), 2);
    ticks(1);
    chk("tl_1", 32'(bus.time_left), 1);
    ticks(1);
    chk("tl_end", 32'(bus.time_left), 0);
    chk("done", 32'(bus.state), 5);
    chk("beep_on", 32'(bus.done_beep), 1);
    ticks(9);
    chk("done_9", 32'(bus.state), 5);
    ticks(1);
    chk("done_exit", 32'(bus.state), 1);
    chk("beep_off", 32'(bus.done_beep), 0);

    mode();
    up(1);
    start();
    step();
    chk("bake2", 32'(bus.state), 4);
    bus.power = 1'b0;
    step();
    chk("pwr_off_st", 32'(bus.state), 0);
    chk("pwr_off_heat", 32'(bus.heater_on), 0);
    chk("pwr_off_tl", 32'(bus.time_left), 0);
    chk("pwr_off_tgt", 32'(bus.target_temp), 350);
    bus.power = 1'b1;
    step();
    chk("pwr_on", 32'(bus.state), 1);

    up(1);
    chk("tgt_355", 32'(bus.target_temp), 355);
    mode();
    up(1);
    bus.cur_temp = 11'd300;
    start();
    step();
    chk("pre2_heat", 32'(bus.heater_on), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_pre_st", 32'(bus.state), 0);
    chk("rst_pre_tgt", 32'(bus.target_temp), 350);
    chk("rst_pre_heat", 32'(bus.heater_on), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/oven_bake_controller.md
Name: oven_bake_controller

Overview:
Sequencing FSM for the oven. Takes the debounced power level, single-cycle button pulses, a 1 Hz tick and the measured oven temperature. Owns the target temperature and bake countdown, drives the heater, and walks SET_TEMP -> SET_TIME -> PREHEAT -> BAKE -> DONE. Sits between the button/clock-divider logic and the seven-segment display formatter, which renders target_temp, time_left or state.

Parameters:
TEMP_DEFAULT, 350, target_temp value after reset (deg F)
TEMP_MIN, 170, lowest settable target
TEMP_MAX, 550, highest settable target
TEMP_STEP, 5, target change per up/down pulse
TIME_STEP, 30, bake-time change per up/down pulse (seconds)
TIME_MAX, 5999, longest settable bake time (99:59)
HYST, 5, heater re-enable band below target in BAKE
DONE_SECS, 10, ticks spent in DONE before auto-return

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  synchronous active-high reset
power  input  1  level: 1 = oven on, 0 = oven off
btn_up  input  1  one-cycle pulse: increase selected field
btn_down  input  1  one-cycle pulse: decrease selected field
btn_mode  input  1  one-cycle pulse: toggle SET_TEMP/SET_TIME
btn_start  input  1  one-cycle pulse: start bake / cancel / acknowledge
tick  input  1  one-cycle pulse once per second
cur_temp  input  11  measured oven temperature, unsigned
heater_on  output  1  heater element enable
target_temp  output  11  current target temperature
time_left  output  17  bake seconds remaining / being set
state  output  3  OFF=0, SET_TEMP=1, SET_TIME=2, PREHEAT=3, BAKE=4, DONE=5
done_beep  output  1  high for the whole of DONE

Behaviour:
- All outputs registered; respond on the first clk edge after the input is sampled (1-cycle latency).
- Reset: state=OFF, heater_on=0, target_temp=TEMP_DEFAULT, time_left=0, done_beep=0, DONE tick counter=0. Reset wins over every other input.
- Priority each cycle: rst > power==0 > btn_start > btn_mode > up/down. Up and down together: no change.
- power==0 in any state: next state OFF, heater_on=0, time_left=0, target_temp retained.
- OFF: power==1 -> SET_TEMP. Buttons and ticks ignored.
- SET_TEMP: up -> target_temp+TEMP_STEP, saturating at TEMP_MAX. Down -> target_temp-TEMP_STEP, saturating at TEMP_MIN. btn_mode -> SET_TIME.
- SET_TIME: up -> time_left+TIME_STEP, saturating at TIME_MAX. Down -> time_left-TIME_STEP, saturating at 0 (no underflow). btn_mode -> SET_TEMP.
- btn_start in SET_TEMP/SET_TIME: -> PREHEAT if time_left>0; ignored if time_left==0.
- PREHEAT: heater_on = (cur_temp < target_temp), evaluated every cycle. cur_temp >= target_temp -> BAKE with heater_on=0. btn_start -> SET_TEMP, heater_on=0, time_left kept. Up/down/mode/tick ignored.
- BAKE:
  - heater_on set when cur_temp < target_temp-HYST, cleared when cur_temp >= target_temp, otherwise held.
  - Each tick decrements time_left. A tick with time_left==1 gives time_left=0, heater_on=0, state DONE.
  - btn_start pauses: -> SET_TEMP, heater_on=0, time_left keeps the remaining seconds.
  - Up/down/mode ignored.
- DONE: heater_on=0, done_beep=1. A tick counter counts ticks; on the DONE_SECS-th tick -> SET_TEMP. Any button pulse -> SET_TEMP immediately. Counter clears on DONE entry.
- target_temp is never outside [TEMP_MIN, TEMP_MAX]. time_left is never above TIME_MAX.
- Illegal state encodings (6, 7) -> OFF next cycle with heater_on=0.

Test Plan:
- rst then power=1 -> state OFF, then SET_TEMP the next cycle. target_temp=350, time_left=0, heater_on=0.
- SET_TEMP, 45 btn_up pulses -> target_temp 550, not 575. Then 80 btn_down pulses -> 170.
- btn_mode, 3 btn_up, 4 btn_down -> time_left 90 then 0. Further btn_down stays 0. btn_start with time_left=0 -> state remains SET_TIME.
- target 350, time 60, start, cur_temp 300 -> PREHEAT, heater_on=1. cur_temp 350 -> BAKE, heater_on=0. cur_temp 344 -> heater_on=1. cur_temp 347 -> still 1. cur_temp 350 -> 0.
- BAKE with time_left=2, two ticks -> time_left 1 then 0, state DONE, done_beep=1. 10 ticks -> SET_TEMP, done_beep=0.
- Mid-BAKE (time_left=40): btn_start -> SET_TEMP with time_left=40. power=0 in BAKE -> OFF, heater_on=0, time_left=0. rst asserted in PREHEAT -> OFF, target_temp=350.
